// File: rtl/audio_cfg_seq.sv
// audio_cfg_seq: audio codec configuration sequencer.
// After reset it writes a fixed 8-entry codec register table through an I2C
// byte master using a req/done handshake. It retries a write after NACK and
// waits a settle delay after the soft-reset write. Once the table is done it
// forwards single runtime register writes from the system side.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cfg_start            pulse; restarts the table (READY/ERR only)
//   wr_req/addr/data     runtime write request (level until wr_ack)
//   wr_ack, wr_err       1-cycle completion pulse and its failure flag
//   i2c_req/dev/word     request level, device address, {reg, data} word
//   i2c_done, i2c_nack   transaction end pulse and its NACK flag
//   cfg_busy/done/err    sequencer status
module audio_cfg_seq #(
    parameter logic [5:0]  WL        = 6'd16,
    parameter logic [6:0]  DEV_ADDR  = 7'h1A,
    parameter logic [1:0]  RETRY_MAX = 2'd3,
    parameter logic [19:0] DELAY_CYC = 20'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_start,
    input  logic        wr_req,
    input  logic [6:0]  wr_addr,
    input  logic [8:0]  wr_data,
    output logic        wr_ack,
    output logic        wr_err,
    output logic        i2c_req,
    output logic [6:0]  i2c_dev,
    output logic [15:0] i2c_word,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned RTY_W  = 2;
    localparam int unsigned DCNT_W = 20;
    localparam int unsigned WORD_W = 16;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(7);

    // Word-length field of the codec interface register.
    localparam logic [1:0] WL_CODE = (WL == 6'd20) ? 2'b01 :
                                     (WL == 6'd24) ? 2'b10 :
                                     (WL == 6'd32) ? 2'b11 : 2'b00;

    typedef enum logic [2:0] {
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DELAY,
        S_READY,
        S_RT_ISSUE,
        S_RT_WAIT,
        S_ERR
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [RTY_W-1:0]  retry, retry_nxt;
    logic [DCNT_W-1:0] delay_cnt, delay_cnt_nxt;
    logic [WORD_W-1:0] word_nxt;
    logic              req_nxt;
    logic              wr_ack_nxt;
    logic              wr_err_nxt;
    logic              cfg_busy_nxt;
    logic              cfg_done_nxt;
    logic              cfg_err_nxt;

    logic retry_ok;
    logic delay_last;
    logic rt_accept;

    // Codec register table: {reg[6:0], data[8:0]}.
    function automatic logic [WORD_W-1:0] table_word(input logic [IDX_W-1:0] i);
        logic [6:0] r;
        logic [8:0] d;
        case (i)
            3'd0:    begin r = 7'h00; d = 9'h000; end
            3'd1:    begin r = 7'h01; d = 9'h01B; end
            3'd2:    begin r = 7'h02; d = 9'h1B0; end
            3'd3:    begin r = 7'h03; d = 9'h06F; end
            3'd4:    begin r = 7'h04; d = {2'b00, WL_CODE, 5'b10000}; end
            3'd5:    begin r = 7'h06; d = 9'h000; end
            3'd6:    begin r = 7'h34; d = 9'h13F; end
            default: begin r = 7'h35; d = 9'h13F; end
        endcase
        return {r, d};
    endfunction

    assign i2c_dev  = DEV_ADDR;
    assign retry_ok = (retry < RETRY_MAX);
    // Widened compare so DELAY_CYC of 0 still leaves DELAY after one cycle.
    assign delay_last = ((DCNT_W + 1)'(delay_cnt) + (DCNT_W + 1)'(1))
                        >= (DCNT_W + 1)'(DELAY_CYC);
    // The cycle carrying wr_ack still sees the old wr_req level; skip it.
    assign rt_accept = wr_req && !wr_ack;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LOAD;
            idx       <= '0;
            retry     <= '0;
            delay_cnt <= '0;
            i2c_word  <= '0;
            i2c_req   <= 1'b0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
            cfg_busy  <= 1'b1;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            retry     <= retry_nxt;
            delay_cnt <= delay_cnt_nxt;
            i2c_word  <= word_nxt;
            i2c_req   <= req_nxt;
            wr_ack    <= wr_ack_nxt;
            wr_err    <= wr_err_nxt;
            cfg_busy  <= cfg_busy_nxt;
            cfg_done  <= cfg_done_nxt;
            cfg_err   <= cfg_err_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:  state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (i2c_done) begin
                    if (!i2c_nack) begin
                        if (idx == '0)            state_nxt = S_DELAY;
                        else if (idx == IDX_LAST) state_nxt = S_READY;
                        else                      state_nxt = S_LOAD;
                    end else if (retry_ok) begin
                        state_nxt = S_LOAD;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_DELAY: begin
                if (delay_last) state_nxt = S_LOAD;
            end
            S_READY: begin
                if (cfg_start)      state_nxt = S_LOAD;
                else if (rt_accept) state_nxt = S_RT_ISSUE;
            end
            S_RT_ISSUE: state_nxt = S_RT_WAIT;
            S_RT_WAIT: begin
                if (i2c_done) begin
                    if (i2c_nack && retry_ok) state_nxt = S_RT_ISSUE;
                    else                      state_nxt = S_READY;
                end
            end
            S_ERR: begin
                if (cfg_start) state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        idx_nxt       = idx;
        retry_nxt     = retry;
        delay_cnt_nxt = delay_cnt;
        word_nxt      = i2c_word;
        req_nxt       = i2c_req;
        wr_ack_nxt    = 1'b0;
        wr_err_nxt    = 1'b0;
        cfg_done_nxt  = cfg_done;
        cfg_err_nxt   = cfg_err;
        cfg_busy_nxt  = !((state_nxt == S_READY) || (state_nxt == S_ERR));

        case (state)
            S_LOAD: word_nxt = table_word(idx);
            S_ISSUE: req_nxt = 1'b1;
            S_WAIT: begin
                if (i2c_done) begin
                    req_nxt = 1'b0;
                    if (!i2c_nack) begin
                        retry_nxt = '0;
                        if (idx == '0) begin
                            delay_cnt_nxt = '0;
                        end else if (idx == IDX_LAST) begin
                            cfg_done_nxt = 1'b1;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end else if (retry_ok) begin
                        retry_nxt = retry + RTY_W'(1);
                    end else begin
                        cfg_err_nxt = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                if (delay_last) begin
                    idx_nxt       = IDX_W'(1);
                    delay_cnt_nxt = '0;
                end else begin
                    delay_cnt_nxt = delay_cnt + DCNT_W'(1);
                end
            end
            S_READY, S_ERR: begin
                if (cfg_start) begin
                    cfg_done_nxt = 1'b0;
                    cfg_err_nxt  = 1'b0;
                    idx_nxt      = '0;
                    retry_nxt    = '0;
                end else if ((state == S_READY) && rt_accept) begin
                    word_nxt = {wr_addr, wr_data};
                end
            end
            S_RT_ISSUE: req_nxt = 1'b1;
            S_RT_WAIT: begin
                if (i2c_done) begin
                    req_nxt = 1'b0;
                    if (!i2c_nack) begin
                        wr_ack_nxt = 1'b1;
                        retry_nxt  = '0;
                    end else if (retry_ok) begin
                        retry_nxt = retry + RTY_W'(1);
                    end else begin
                        wr_ack_nxt = 1'b1;
                        wr_err_nxt = 1'b1;
                        retry_nxt  = '0;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_audio_cfg_seq.sv
// tb_audio_cfg_seq: directed bench for audio_cfg_seq with a scripted I2C
// slave that answers each request two cycles after it is seen and NACKs a
// chosen word a chosen number of times.
`timescale 1ns/1ps
module tb_audio_cfg_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic        wr_req;
    logic [6:0]  wr_addr;
    logic [8:0]  wr_data;
    logic        wr_ack, wr_err;
    logic        i2c_req;
    logic [6:0]  i2c_dev;
    logic [15:0] i2c_word;
    logic        i2c_done, i2c_nack;
    logic        cfg_busy, cfg_done, cfg_err;

    // Second instance with WL=24 runs in lockstep on the same inputs.
    logic        wr_ack24, wr_err24, i2c_req24, cfg_busy24, cfg_done24, cfg_err24;
    logic [6:0]  i2c_dev24;
    logic [15:0] i2c_word24;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] log_w[$];
    logic [15:0] log_w24[$];
    int          log_t[$];
    logic [15:0] nack_word = 16'hFFFF;
    int          nack_left = 0;

    logic [15:0] exp_tbl [8] = '{16'h0000, 16'h021B, 16'h05B0, 16'h066F,
                                 16'h0810, 16'h0C00, 16'h693F, 16'h6B3F};

    audio_cfg_seq #(.WL(6'd16), .DEV_ADDR(7'h1A), .RETRY_MAX(2'd3), .DELAY_CYC(20'd10)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .i2c_req(i2c_req), .i2c_dev(i2c_dev), .i2c_word(i2c_word),
        .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    audio_cfg_seq #(.WL(6'd24), .DEV_ADDR(7'h1A), .RETRY_MAX(2'd3), .DELAY_CYC(20'd10)) dut24 (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack24), .wr_err(wr_err24),
        .i2c_req(i2c_req24), .i2c_dev(i2c_dev24), .i2c_word(i2c_word24),
        .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .cfg_busy(cfg_busy24), .cfg_done(cfg_done24), .cfg_err(cfg_err24)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scripted I2C slave: logs each new request, answers two cycles later.
    initial begin : slave
        bit busy_s;
        int lat;
        busy_s   = 1'b0;
        lat      = 0;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
            if (i2c_req === 1'b1) begin
                if (!busy_s) begin
                    busy_s = 1'b1;
                    lat    = 0;
                    log_w.push_back(i2c_word);
                    log_w24.push_back(i2c_word24);
                    log_t.push_back(cyc);
                end else begin
                    lat++;
                    if (lat == 2) begin
                        busy_s   = 1'b0;
                        i2c_done = 1'b1;
                        if (i2c_word == nack_word && nack_left > 0) begin
                            i2c_nack = 1'b1;
                            nack_left--;
                        end
                    end
                end
            end else begin
                busy_s = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log;
        log_w.delete();
        log_w24.delete();
        log_t.delete();
    endtask

    task automatic pulse_start;
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
    endtask

    task automatic wait_settle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (cfg_done === 1'b1 || cfg_err === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ack(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (wr_ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int count_word(input logic [15:0] w);
        int c = 0;
        foreach (log_w[i]) if (log_w[i] === w) c++;
        return c;
    endfunction

    task automatic test_reset;
        rst = 1'b1; cfg_start = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        tick(3);
        n_checks++;
        if ({i2c_req, wr_ack, wr_err, cfg_done, cfg_err, cfg_busy} !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000001",
                     {i2c_req, wr_ack, wr_err, cfg_done, cfg_err, cfg_busy});
        end
        n_checks++;
        if (i2c_word !== 16'h0000) begin
            n_fail++; $display("FAIL reset_word: got %h want 0000", i2c_word);
        end
        n_checks++;
        if (i2c_dev !== 7'h1A) begin
            n_fail++; $display("FAIL reset_dev: got %h want 1a", i2c_dev);
        end
        n_checks++;
        if (log_w.size() !== 0) begin
            n_fail++; $display("FAIL reset_no_txn: got %0d txns want 0", log_w.size());
        end
    endtask

    task automatic test_init;
        bit ok;
        clear_log();
        rst = 1'b0;
        wait_settle(1000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL init_timeout: cfg_done/err never rose"); end
        n_checks++;
        if ({cfg_done, cfg_err, cfg_busy} !== 3'b100) begin
            n_fail++; $display("FAIL init_status: got %b want 100", {cfg_done, cfg_err, cfg_busy});
        end
        n_checks++;
        if (log_w.size() !== 8) begin
            n_fail++; $display("FAIL init_count: got %0d want 8", log_w.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < log_w.size()) begin
                n_checks++;
                if (log_w[i] !== exp_tbl[i]) begin
                    n_fail++; $display("FAIL init_word%0d: got %h want %h", i, log_w[i], exp_tbl[i]);
                end
            end
        end
        if (log_w24.size() > 4) begin
            n_checks++;
            if (log_w24[4] !== 16'h0850) begin
                n_fail++; $display("FAIL wl24_word: got %h want 0850", log_w24[4]);
            end
        end
        n_checks++;
        if ({wr_ack24, wr_err24, i2c_req24, cfg_busy24, cfg_done24, cfg_err24, i2c_dev24}
            !== {6'b000010, 7'h1A}) begin
            n_fail++; $display("FAIL wl24_status: got %b want 0000100011010",
                {wr_ack24, wr_err24, i2c_req24, cfg_busy24, cfg_done24, cfg_err24, i2c_dev24});
        end
        if (log_t.size() > 2) begin
            n_checks++;
            if (log_t[1] - log_t[0] !== 15) begin
                n_fail++; $display("FAIL delay_gap: got %0d want 15", log_t[1] - log_t[0]);
            end
            n_checks++;
            if (log_t[2] - log_t[1] !== 5) begin
                n_fail++; $display("FAIL normal_gap: got %0d want 5", log_t[2] - log_t[1]);
            end
        end
    endtask

    task automatic test_retry_ok;
        bit ok;
        clear_log();
        nack_word = 16'h066F; nack_left = 2;
        pulse_start();
        n_checks++;
        if ({cfg_done, cfg_busy} !== 2'b01) begin
            n_fail++; $display("FAIL restart_clear: got %b want 01", {cfg_done, cfg_busy});
        end
        wait_settle(1000, ok);
        n_checks++;
        if (!ok || cfg_done !== 1'b1 || cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL retry_ok_done: got done=%b err=%b want 1 0", cfg_done, cfg_err);
        end
        n_checks++;
        if (count_word(16'h066F) !== 3 || log_w.size() !== 10) begin
            n_fail++; $display("FAIL retry_ok_issues: got %0d of 066f, %0d total want 3, 10",
                               count_word(16'h066F), log_w.size());
        end
        if (log_t.size() > 4) begin
            n_checks++;
            if (log_t[4] - log_t[3] !== 5) begin
                n_fail++; $display("FAIL retry_gap: got %0d want 5", log_t[4] - log_t[3]);
            end
        end
    endtask

    task automatic test_retry_fail;
        bit ok;
        clear_log();
        nack_word = 16'h066F; nack_left = 4;
        pulse_start();
        wait_settle(1000, ok);
        n_checks++;
        if (!ok || {cfg_err, cfg_done, cfg_busy} !== 3'b100) begin
            n_fail++; $display("FAIL retry_fail_status: got %b want 100", {cfg_err, cfg_done, cfg_busy});
        end
        n_checks++;
        if (count_word(16'h066F) !== 4 || log_w.size() !== 7) begin
            n_fail++; $display("FAIL retry_fail_issues: got %0d of 066f, %0d total want 4, 7",
                               count_word(16'h066F), log_w.size());
        end
        n_checks++;
        if (count_word(16'h0810) !== 0) begin
            n_fail++; $display("FAIL retry_fail_entry4: got %0d issues want 0", count_word(16'h0810));
        end
        tick(20);
        n_checks++;
        if (log_w.size() !== 7 || cfg_err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got %0d txns err=%b want 7 1", log_w.size(), cfg_err);
        end
    endtask

    task automatic test_restart_from_err;
        bit ok;
        clear_log();
        nack_left = 0;
        pulse_start();
        n_checks++;
        if ({cfg_err, cfg_busy} !== 2'b01) begin
            n_fail++; $display("FAIL err_restart_clear: got %b want 01", {cfg_err, cfg_busy});
        end
        wait_settle(1000, ok);
        n_checks++;
        if (!ok || cfg_done !== 1'b1 || log_w.size() !== 8) begin
            n_fail++; $display("FAIL err_restart_done: got done=%b txns=%0d want 1 8", cfg_done, log_w.size());
        end
        if (log_w.size() > 0) begin
            n_checks++;
            if (log_w[0] !== 16'h0000) begin
                n_fail++; $display("FAIL err_restart_first: got %h want 0000", log_w[0]);
            end
        end
    endtask

    task automatic test_rt_during_init;
        bit ok;
        clear_log();
        wr_addr = 7'h34; wr_data = 9'h120; wr_req = 1'b1;
        pulse_start();
        wait_ack(1000, ok);
        n_checks++;
        if (!ok || cfg_done !== 1'b1 || log_w.size() !== 9) begin
            n_fail++; $display("FAIL rt_init_order: got ack=%b done=%b txns=%0d want 1 1 9",
                               ok, cfg_done, log_w.size());
        end
        if (log_w.size() > 8) begin
            n_checks++;
            if (log_w[8] !== 16'h6920) begin
                n_fail++; $display("FAIL rt_word: got %h want 6920", log_w[8]);
            end
        end
        n_checks++;
        if (wr_err !== 1'b0) begin
            n_fail++; $display("FAIL rt_ok_err: got %b want 0", wr_err);
        end
        wr_req = 1'b0;
        tick(1);
        n_checks++;
        if (wr_ack !== 1'b0) begin
            n_fail++; $display("FAIL rt_ack_pulse: got %b want 0", wr_ack);
        end
        tick(5);
        n_checks++;
        if (log_w.size() !== 9) begin
            n_fail++; $display("FAIL rt_single_txn: got %0d want 9", log_w.size());
        end
    endtask

    task automatic test_rt_nack;
        bit ok;
        clear_log();
        nack_word = 16'h6920; nack_left = 4;
        wr_req = 1'b1;
        wait_ack(200, ok);
        n_checks++;
        if (!ok || wr_err !== 1'b1 || cfg_done !== 1'b1) begin
            n_fail++; $display("FAIL rt_nack_status: got ack=%b err=%b done=%b want 1 1 1", ok, wr_err, cfg_done);
        end
        n_checks++;
        if (count_word(16'h6920) !== 4 || log_w.size() !== 4) begin
            n_fail++; $display("FAIL rt_nack_issues: got %0d of 6920, %0d total want 4, 4",
                               count_word(16'h6920), log_w.size());
        end
        wr_req = 1'b0;
        tick(1);
        n_checks++;
        if ({wr_ack, wr_err, cfg_busy} !== 3'b000) begin
            n_fail++; $display("FAIL rt_nack_after: got %b want 000", {wr_ack, wr_err, cfg_busy});
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        clear_log();
        nack_left = 0;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i2c_req === 1'b1 && i2c_word === 16'h0C00) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL mid_reach_entry5: got no 0c00 request"); end
        rst = 1'b1;
        tick(1);
        n_checks++;
        if ({i2c_req, cfg_busy, cfg_done} !== 3'b010) begin
            n_fail++; $display("FAIL mid_reset_drop: got %b want 010", {i2c_req, cfg_busy, cfg_done});
        end
        tick(2);
        clear_log();
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (log_w.size() > 0) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || log_w[0] !== 16'h0000) begin
            n_fail++; $display("FAIL mid_first_word: got %h want 0000", ok ? log_w[0] : 16'hxxxx);
        end
        wait_settle(1000, ok);
        n_checks++;
        if (!ok || cfg_done !== 1'b1 || log_w.size() !== 8) begin
            n_fail++; $display("FAIL mid_rerun: got done=%b txns=%0d want 1 8", cfg_done, log_w.size());
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_retry_ok();
        test_retry_fail();
        test_restart_from_err();
        test_rt_during_init();
        test_rt_nack();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_cfg_seq.md
Name: audio_cfg_seq

Overview:
Configuration sequencer for the audio codec control path. After reset it walks a fixed 8-entry codec register table and issues each write as a 16-bit control word, {reg[6:0], data[8:0]}, to the I2C byte master over a req/done handshake. It handles NACK retries and the post-soft-reset settle delay. Once initialised, it arbitrates single runtime register writes (volume, mute) from the system side onto the same I2C master.

Parameters:
WL, 6'd16, audio word length programmed into the codec interface register; legal values 16/20/24/32.
DEV_ADDR, 7'h1A, codec 7-bit I2C device address, driven on i2c_dev.
RETRY_MAX, 2'd3, maximum re-issues of one word after NACK before error.
DELAY_CYC, 20'd50000, clk cycles to wait after the table entry 0 (soft reset) write completes.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cfg_start  input  1  pulse; restarts the table from entry 0 (honoured in READY and ERR only)
wr_req  input  1  runtime write request; level, held until wr_ack
wr_addr  input  7  runtime codec register address
wr_data  input  9  runtime codec register data
wr_ack  output  1  1-cycle pulse; runtime write finished
wr_err  output  1  valid with wr_ack; 1 = runtime write failed after retries
i2c_req  output  1  transaction request to I2C master; level
i2c_dev  output  7  device address (constant DEV_ADDR)
i2c_word  output  16  {reg, data} word to transmit
i2c_done  input  1  1-cycle pulse from master; transaction ended
i2c_nack  input  1  valid with i2c_done; 1 = slave NACK
cfg_busy  output  1  1 whenever state is not READY or ERR
cfg_done  output  1  level; table completed without error
cfg_err  output  1  level; table entry failed after retries

Behaviour:
- Reset: i2c_req=0, i2c_word=0, wr_ack=0, wr_err=0, cfg_done=0, cfg_err=0, cfg_busy=1, idx=0, retry=0, delay counter=0, state=LOAD. The table sequence starts automatically after rst falls.
- Table, idx: reg, data:
  - 0: 0x00, 0x000 (soft reset)
  - 1: 0x01, 0x01B
  - 2: 0x02, 0x1B0
  - 3: 0x03, 0x06F
  - 4: 0x04, {2'b00, wl, 5'b10000}, where wl = 00/01/10/11 for WL = 16/20/24/32; any other WL value maps to 00.
  - 5: 0x06, 0x000 (slave mode)
  - 6: 0x34, 0x13F
  - 7: 0x35, 0x13F
- States:
  - LOAD: i2c_word <= table[idx]; go to ISSUE next cycle.
  - ISSUE: i2c_req <= 1; go to WAIT.
  - WAIT: hold i2c_req and i2c_word until i2c_done. On done, i2c_req <= 0 in the same edge.
    - Ack: retry <= 0. If idx==0, go to DELAY. If idx==7, go to READY and set cfg_done=1. Otherwise idx++ and go to LOAD.
    - NACK with retry<RETRY_MAX: retry++ and go to LOAD (same idx).
    - NACK with retry==RETRY_MAX: go to ERR and set cfg_err=1.
  - DELAY: count DELAY_CYC cycles, then idx <= 1 and go to LOAD.
  - READY: idle. cfg_start has priority over wr_req.
    - cfg_start: clear cfg_done/cfg_err, idx=0, retry=0, go to LOAD.
    - wr_req: latch {wr_addr, wr_data} into i2c_word and go to RT_ISSUE.
  - RT_ISSUE / RT_WAIT: same handshake and retry rules as ISSUE/WAIT.
    - Ack: pulse wr_ack (wr_err=0), retry=0, return to READY.
    - Final NACK: pulse wr_ack with wr_err=1, return to READY. cfg_done stays 1.
  - ERR: sticky until rst or cfg_start; cfg_start restarts as in READY.
- wr_req outside READY is not acknowledged; it remains pending and is served on entry to READY. After wr_ack the requester must drop wr_req. If wr_req is still high the cycle after the ack, it is treated as a new request.
- i2c_req is low for at least 1 cycle between consecutive transactions, including retries. Gap from done to the next req rising edge is 2 cycles (LOAD, ISSUE).
- i2c_nack is ignored when i2c_done=0. An i2c_done arriving in any state other than WAIT/RT_WAIT is ignored.
- A synchronous rst mid-transaction drops i2c_req on the next edge and restarts the whole sequence.

Test Plan:
- Clean init, slave always ACKs, DELAY_CYC=10 -> exactly 8 transactions with words 0x0000, 0x021B, 0x05B0, 0x066F, 0x0810, 0x0C00, 0x693F, 0x6B3F. There are exactly 10 idle cycles between the entry 0 done and the entry 1 LOAD. cfg_done=1 and cfg_busy=0 after the 8th done.
- WL=24 -> entry 4 word = 0x0850.
- Entry 3 NACKs twice, then ACKs -> 0x066F is issued 3 times and cfg_done=1. Entry 3 NACKs 4 times -> 4 issues, cfg_err=1, no entry 4 issued. A following cfg_start -> full sequence reruns from 0x0000.
- wr_req with addr 0x34, data 0x120 asserted during init -> no ack until READY. Then one transaction with word 0x6920, followed by a single-cycle wr_ack with wr_err=0.
- Runtime write NACKed 4 times -> wr_ack with wr_err=1, and cfg_done remains 1.
- rst asserted in WAIT of entry 5 -> i2c_req=0 the next cycle. After release, the first word issued is 0x0000.
